// File: rtl/sd_block_cache_pkg.sv
// Shared constants and FSM state encoding for the single-entry SD block cache.
package sd_block_cache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = 9;
  localparam int unsigned BLK_W  = ADDR_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4
  } cache_state_e;

endpackage

// File: rtl/sd_block_cache_if.sv
// Client and SPI-engine signals of the block cache.
//   read/write/addr  client request (master drives)
//   ready/write_ram  hit indications back to the client
//   busy             SPI engine status (master drives)
//   read_spi/write_spi/block  transfer requests to the SPI engine
interface sd_block_cache_if;
  import sd_block_cache_pkg::*;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              ready;
  logic              write_ram;
  logic              read_spi;
  logic              write_spi;
  logic [BLK_W-1:0]  block;

  modport master (
    output read, write, addr, busy,
    input  ready, write_ram, read_spi, write_spi, block
  );

  modport slave (
    input  read, write, addr, busy,
    output ready, write_ram, read_spi, write_spi, block
  );

endinterface

// File: rtl/sd_block_cache.sv
// Single-entry write-back cache tracking which 512-byte SD block is held in the
// external block RAM. Misses sequence an optional write-back then a fill.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sd_block_cache_if.slave: client request/ready, SPI request/busy
module sd_block_cache
  import sd_block_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  sd_block_cache_if.slave    bus
);

  cache_state_e     state_q, state_d;
  logic [BLK_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;
  logic             dirty_q, dirty_d;
  logic             read_spi_q, write_spi_q;
  logic [BLK_W-1:0] addr_blk;
  logic             req;
  logic             hit;
  logic             ready_c;
  logic             write_ram_c;
  logic             unused_off;

  assign addr_blk   = bus.addr[ADDR_W-1:OFF_W];
  assign unused_off = ^bus.addr[OFF_W-1:0];
  assign req        = bus.read | bus.write;
  assign hit        = valid_q & (addr_blk == tag_q);

  // State, tag and strobe registers; strobes follow the next state so they
  // assert the cycle after a miss is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      dirty_q     <= 1'b0;
      read_spi_q  <= 1'b0;
      write_spi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      read_spi_q  <= (state_d == RD_REQ);
      write_spi_q <= (state_d == WB_REQ);
    end
  end

  // Next-state and hit decode.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    ready_c     = 1'b0;
    write_ram_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_c     = req & hit;
        write_ram_c = bus.write & hit;
        if (bus.write && hit) begin
          dirty_d = 1'b1;
        end
        if (req && !hit && !bus.busy) begin
          if (valid_q && dirty_q) begin
            state_d = WB_REQ;
          end else begin
            tag_d   = addr_blk;
            state_d = RD_REQ;
          end
        end
      end
      WB_REQ: begin
        if (bus.busy) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (!bus.busy) begin
          dirty_d = 1'b0;
          tag_d   = addr_blk;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bus.busy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (!bus.busy) begin
          valid_d = 1'b1;
          dirty_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready     = ready_c;
  assign bus.write_ram = write_ram_c;
  assign bus.read_spi  = read_spi_q;
  assign bus.write_spi = write_spi_q;
  // Tag already holds the new block while filling and the old one while writing back.
  assign bus.block     = tag_q;

endmodule

// File: tb/tb_sd_block_cache.sv
// Directed bench for sd_block_cache: hits, clean/dirty read and write misses,
// idle with no request, and reset during a fill.
module tb_sd_block_cache;
  import sd_block_cache_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sd_block_cache_if bus ();

  sd_block_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine accepts the request, stays busy n cycles, then drops busy.
  task automatic busy_pulse(input int n);
    bus.busy = 1'b1;
    repeat (n) tick();
    bus.busy = 1'b0;
    tick();
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a);
    bus.read  = rd;
    bus.write = wr;
    bus.addr  = a;
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.busy  = 1'b0;
    repeat (2) tick();
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rdspi", 32'(bus.read_spi), 32'd0);
    check("rst_wrspi", 32'(bus.write_spi), 32'd0);
    check("rst_block", 32'(bus.block), 32'd0);
    rst_n = 1'b1;
    tick();

    // Cold read miss of block 0.
    req(1'b1, 1'b0, 32'h0000_0000);
    check("cold_ready0", 32'(bus.ready), 32'd0);
    tick();
    check("cold_rdspi", 32'(bus.read_spi), 32'd1);
    check("cold_block", 32'(bus.block), 32'h0);
    check("cold_ready1", 32'(bus.ready), 32'd0);
    busy_pulse(5);
    check("cold_hit", 32'(bus.ready), 32'd1);
    check("cold_wram", 32'(bus.write_ram), 32'd0);
    check("cold_rdspi_off", 32'(bus.read_spi), 32'd0);

    // Hit in the same block.
    req(1'b1, 1'b0, 32'h0000_0055);
    check("hit55_ready", 32'(bus.ready), 32'd1);
    tick();
    check("hit55_rdspi", 32'(bus.read_spi), 32'd0);
    check("hit55_wrspi", 32'(bus.write_spi), 32'd0);

    // Clean read miss of block 0x180.
    req(1'b1, 1'b0, 32'h0003_0005);
    check("miss180_ready", 32'(bus.ready), 32'd0);
    tick();
    check("miss180_rdspi", 32'(bus.read_spi), 32'd1);
    check("miss180_block", 32'(bus.block), 32'h180);
    busy_pulse(3);
    check("miss180_hit", 32'(bus.ready), 32'd1);

    // No request: nothing raised even though address is ignored.
    req(1'b0, 1'b0, 32'h0002_0005);
    check("noreq_ready", 32'(bus.ready), 32'd0);
    tick();
    check("noreq_rdspi", 32'(bus.read_spi), 32'd0);
    check("noreq_wrspi", 32'(bus.write_spi), 32'd0);

    // Write hit marks the block dirty.
    req(1'b0, 1'b1, 32'h0003_0008);
    check("wrhit_ready", 32'(bus.ready), 32'd1);
    check("wrhit_wram", 32'(bus.write_ram), 32'd1);
    tick();
    check("wrhit_wrspi", 32'(bus.write_spi), 32'd0);

    // Dirty read miss: write back 0x180, then fill 0.
    req(1'b1, 1'b0, 32'h0000_0009);
    check("dmiss_ready0", 32'(bus.ready), 32'd0);
    tick();
    check("dmiss_wrspi", 32'(bus.write_spi), 32'd1);
    check("dmiss_rdspi0", 32'(bus.read_spi), 32'd0);
    check("dmiss_wbblock", 32'(bus.block), 32'h180);
    busy_pulse(4);
    check("dmiss_rdspi", 32'(bus.read_spi), 32'd1);
    check("dmiss_wrspi_off", 32'(bus.write_spi), 32'd0);
    check("dmiss_rdblock", 32'(bus.block), 32'h0);
    busy_pulse(2);
    check("dmiss_hit", 32'(bus.ready), 32'd1);

    // Clean write miss of block 0x200.
    req(1'b0, 1'b1, 32'h0004_0009);
    check("cwmiss_wram0", 32'(bus.write_ram), 32'd0);
    tick();
    check("cwmiss_rdspi", 32'(bus.read_spi), 32'd1);
    check("cwmiss_wrspi", 32'(bus.write_spi), 32'd0);
    check("cwmiss_block", 32'(bus.block), 32'h200);
    check("cwmiss_wram1", 32'(bus.write_ram), 32'd0);
    busy_pulse(3);
    check("cwmiss_wram", 32'(bus.write_ram), 32'd1);
    check("cwmiss_ready", 32'(bus.ready), 32'd1);
    tick();

    // Dirty write miss: write back 0x200, fill 0x300, then write hit.
    req(1'b0, 1'b1, 32'h0006_0009);
    tick();
    check("dwmiss_wrspi", 32'(bus.write_spi), 32'd1);
    check("dwmiss_wbblock", 32'(bus.block), 32'h200);
    busy_pulse(3);
    check("dwmiss_rdspi", 32'(bus.read_spi), 32'd1);
    check("dwmiss_rdblock", 32'(bus.block), 32'h300);
    busy_pulse(3);
    check("dwmiss_wram", 32'(bus.write_ram), 32'd1);
    check("dwmiss_ready", 32'(bus.ready), 32'd1);
    tick();

    // Reset during RD_WAIT abandons the fill; cache comes back invalid and clean.
    req(1'b1, 1'b0, 32'h0008_0000);
    tick();
    check("rstfill_wrspi", 32'(bus.write_spi), 32'd1);
    busy_pulse(2);
    check("rstfill_rdspi", 32'(bus.read_spi), 32'd1);
    bus.busy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rstfill_ready", 32'(bus.ready), 32'd0);
    check("rstfill_rd_off", 32'(bus.read_spi), 32'd0);
    check("rstfill_wr_off", 32'(bus.write_spi), 32'd0);
    check("rstfill_block", 32'(bus.block), 32'd0);
    bus.busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("refill_ready0", 32'(bus.ready), 32'd1 - 32'd1);
    check("refill_rdspi", 32'(bus.read_spi), 32'd1);
    check("refill_wrspi", 32'(bus.write_spi), 32'd0);
    check("refill_block", 32'(bus.block), 32'h400);
    busy_pulse(2);
    check("refill_hit", 32'(bus.ready), 32'd1);

    req(1'b0, 1'b0, 32'h0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
